// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game round sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        SHOW = 3'd2,
        DONE = 3'd3
    } state_t;

    localparam int SCORE_W   = 6;
    localparam int SCORE_MAX = 63;
    localparam int TIME_W    = 6;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v
    );
        return (v == SCORE_W'(SCORE_MAX)) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/target_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick the next target.
module target_lfsr (
    input  logic       clkIn,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] state
);

    logic fb;

    assign fb = state[7] ^ state[5] ^ state[4] ^ state[3];

    // A zero seed would lock the register up, so substitute 1
    always_ff @(posedge clkIn) begin
        if (reset) begin
            state <= (seed == 8'd0) ? 8'd1 : seed;
        end else begin
            state <= {state[6:0], fb};
        end
    end

endmodule

// File: rtl/target_round_sequencer.sv
// One timed round of the reaction game: start, targets, scoring, end.
// Define MISS_PENALTY_EN to make wrong presses cost one point.
module target_round_sequencer
    import game_pkg::*;
#(
    parameter int         GAME_SECONDS = 30,
    parameter int         NUM_TARGETS  = 4,
    parameter int         TARGET_TICKS = 2,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic                   clkIn,
    input  logic                   reset,
    input  logic                   tick_1hz,
    input  logic                   start_game,
    input  logic [NUM_TARGETS-1:0] btn,
    output logic [NUM_TARGETS-1:0] target_onehot,
    output logic [SCORE_W-1:0]     score,
    output logic [TIME_W-1:0]      time_left,
    output logic                   game_active,
    output logic                   game_over,
    output logic                   timer_expired
);

    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    state_t                 state;
    state_t                 state_nx;
    logic [7:0]             lfsr;
    logic                   lfsr_unused;
    logic                   start_d;
    logic                   start_pulse;
    logic [NUM_TARGETS-1:0] btn_d;
    logic [NUM_TARGETS-1:0] hit;
    logic [2:0]             window;
    logic [2:0]             window_nx;
    logic [IDX_W-1:0]       prev_idx;
    logic [IDX_W-1:0]       prev_nx;
    logic [IDX_W-1:0]       idx_raw;
    logic [IDX_W-1:0]       idx;
    logic [SCORE_W-1:0]     score_nx;
    logic [TIME_W-1:0]      time_nx;
    logic [NUM_TARGETS-1:0] target_nx;
    logic                   lit_hit;
    logic                   wrong_hit;
    logic                   tick_live;
    logic                   expire;
    logic                   win_out;

    target_lfsr u_lfsr (
        .clkIn (clkIn),
        .reset (reset),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    assign lfsr_unused = ^lfsr;
    assign idx_raw     = lfsr[IDX_W-1:0];
    // Never repeat the previous target; wraps since NUM_TARGETS is 2^n
    assign idx         = (idx_raw == prev_idx) ? idx_raw + 1'b1 : idx_raw;

    assign lit_hit   = |(hit & target_onehot);
    assign wrong_hit = |(hit & ~target_onehot);
    assign tick_live = tick_1hz && (state == ARM || state == SHOW);
    assign expire    = tick_live && (time_left == TIME_W'(1));
    assign win_out   = tick_1hz && (window == 3'd1);

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state         <= IDLE;
            score         <= '0;
            time_left     <= TIME_W'(GAME_SECONDS);
            target_onehot <= '0;
            game_active   <= 1'b0;
            game_over     <= 1'b0;
            timer_expired <= 1'b0;
            start_d       <= 1'b0;
            start_pulse   <= 1'b0;
            btn_d         <= '0;
            hit           <= '0;
            window        <= '0;
            prev_idx      <= '0;
        end else begin
            state         <= state_nx;
            score         <= score_nx;
            time_left     <= time_nx;
            target_onehot <= target_nx;
            game_active   <= (state_nx == ARM) || (state_nx == SHOW);
            game_over     <= (state_nx == DONE);
            timer_expired <= expire;
            start_d       <= start_game;
            start_pulse   <= start_game & ~start_d;
            btn_d         <= btn;
            hit           <= btn & ~btn_d;
            window        <= window_nx;
            prev_idx      <= prev_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = start_pulse ? ARM : IDLE;
            ARM:     state_nx = expire ? DONE : SHOW;
            SHOW: begin
                if (expire)
                    state_nx = DONE;
                else if (lit_hit || win_out)
                    state_nx = ARM;
                else
                    state_nx = SHOW;
            end
            DONE:    state_nx = start_pulse ? ARM : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        score_nx  = score;
        time_nx   = time_left;
        window_nx = window;
        prev_nx   = prev_idx;
        target_nx = '0;
        if (tick_live)
            time_nx = time_left - 1'b1;
        case (state)
            IDLE, DONE: begin
                if (start_pulse) begin
                    score_nx = '0;
                    time_nx  = TIME_W'(GAME_SECONDS);
                end
            end
            ARM: begin
                prev_nx   = idx;
                window_nx = 3'(TARGET_TICKS);
                if (!expire)
                    target_nx = NUM_TARGETS'(1) << idx;
            end
            SHOW: begin
                if (tick_1hz && window != 3'd0)
                    window_nx = window - 3'd1;
                if (lit_hit)
                    score_nx = sat_inc(score);
`ifdef MISS_PENALTY_EN
                else if (wrong_hit && score != '0)
                    score_nx = score - 1'b1;
`endif
                if (state_nx == SHOW)
                    target_nx = target_onehot;
            end
            default: ;
        endcase
    end

    // Only consumed under MISS_PENALTY_EN
    logic wrong_unused;
    assign wrong_unused = wrong_hit;

endmodule

// File: doc/target_round_sequencer.md
Name: target_round_sequencer

Overview:
- Sequences one timed round of the reaction game: start handshake, countdown, target selection, hit/miss scoring, and end of round.
- Sits between the debounced button/tick front end and the LED/seven-segment display drivers.
- Owns the round timer and the score register.
- Drives which target LED is lit and for how long.

Parameters:
- GAME_SECONDS, 30, round length in tick_1hz pulses (1..63).
- NUM_TARGETS, 4, number of target LEDs/buttons; must be a power of 2 (2..8).
- TARGET_TICKS, 2, tick_1hz pulses a target stays lit before it counts as a miss (1..7).
- LFSR_SEED, 8'hA5, nonzero reset seed of the target LFSR.

Ports:
- clkIn  input  1  100 MHz system clock; only clock in the block.
- reset  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-clkIn-cycle enable pulse, once per second.
- start_game  input  1  debounced level; a rising edge requests a round.
- btn  input  NUM_TARGETS  debounced button levels.
- target_onehot  output  NUM_TARGETS  lit target; valid only in SHOW, else 0.
- score  output  6  hits this round, saturating at 63.
- time_left  output  6  seconds remaining.
- game_active  output  1  high in ARM and SHOW.
- game_over  output  1  high in DONE.
- timer_expired  output  1  one-cycle pulse on the cycle DONE is entered.

Behaviour:
- Reset values:
  - state IDLE, score 0, time_left = GAME_SECONDS.
  - target_onehot 0, game_active 0, game_over 0, timer_expired 0.
  - LFSR = LFSR_SEED; window counter 0; edge-detect registers 0.
- Reset asserted in any state returns all of the above on the next clkIn edge.
- All outputs are registered.
- Edge detection:
  - start_pulse = start_game & ~start_game_d.
  - hit_pulse[i] = btn[i] & ~btn_d[i].
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every clkIn cycle, including in IDLE.
  - Never reaches 0.
- IDLE:
  - On start_pulse, go to ARM and load score 0, time_left GAME_SECONDS.
- ARM (exactly 1 cycle):
  - idx = LFSR[log2(NUM_TARGETS)-1:0]; if idx == prev_idx, use idx+1 mod NUM_TARGETS.
  - Store idx in prev_idx, load window = TARGET_TICKS, go to SHOW.
  - target_onehot becomes 1<<idx on entry to SHOW.
- SHOW:
  - hit_pulse on the lit index: score += 1 (saturating at 63), go to ARM.
  - Window reaches 0 on a tick: miss, score unchanged, go to ARM.
  - hit_pulse on any other button is ignored (see optional feature).
  - Multiple simultaneous rising edges that include the lit index count as one hit.
- Timer:
  - In ARM and SHOW, each tick_1hz decrements time_left.
  - The tick that takes time_left from 1 to 0 moves the block to DONE next cycle and pulses timer_expired.
- Same-cycle events:
  - Hit and expiring tick: the hit is scored, then DONE.
  - Expiring tick overrides target-window expiry.
- DONE:
  - target_onehot 0; score and time_left (0) are held.
  - start_pulse starts a new round directly (same loads as in IDLE, go to ARM).
- No other transitions leave DONE except reset.
- start_pulse in ARM/SHOW is ignored.
- Latency: button edge to score update is 2 clkIn cycles (edge register, then score register).

Optional Feature:
- Macro: MISS_PENALTY_EN.
- Defined:
  - In SHOW, a hit_pulse on any non-lit button with no lit-button edge in the same cycle decrements score, saturating at 0.
  - State is unchanged; the target stays lit.
- Undefined: wrong presses have no effect.

Decomposition:
- Shared package game_pkg:
  - State encoding: IDLE=0, ARM=1, SHOW=2, DONE=3 (3-bit state field, spare codes decode to IDLE).
  - SCORE_W=6, SCORE_MAX=63, TIME_W=6.
- Sub-module target_lfsr:
  - Ports: clkIn, reset, seed in, 8-bit state out.
  - Instantiated once.

Test Plan (GAME_SECONDS=5, TARGET_TICKS=2, NUM_TARGETS=4, tick_1hz every 20 cycles):
- Reset then start_game rise: one cycle in ARM, then SHOW.
  - Required: game_active=1, time_left=5, score=0, target_onehot has exactly one bit set.
- Press the lit button 3 times, each within the window:
  - score = 1, 2, 3, each 2 cycles after the edge.
  - The new target differs from the previous one each time.
- No press for 2 ticks: target advances to a different index, score unchanged.
- Run 5 ticks:
  - timer_expired pulses once, game_over=1, time_left=0, target_onehot=0.
  - score held at its value.
- Lit-button edge in the same cycle as the 5th tick: score incremented, then DONE.
- Assert reset mid-SHOW with score=2, then separately restart from DONE:
  - Reset: next cycle state IDLE, score 0, time_left 5.
  - Restart from DONE: start_game rise gives ARM with score 0.
  - Under MISS_PENALTY_EN: wrong button with score=2 gives 1; wrong button with score=0 stays 0.
